// File: rtl/cpu_timing.sv
// cpu_timing: 6502 cycle sequencer. Produces sync and the T-state count, runs
// the reset and interrupt entry sequences, and stretches instructions on page
// crossings and taken branches.
// Optional interrupt entry is built when CPU_TIMING_INT_EN is defined; without
// it irq_n/i_flag are ignored and int_seq stays 0.
// Every output is a register. Inputs are sampled on the clock edge that opens
// the cycle they refer to: len/ext_ok/is_branch/branch_taken on the edge from
// T0 into T1, and "page_cross at tstate N" is the value present on the edge
// into TN. This lets last_cycle already include an extension in that cycle.
module cpu_timing #(
  parameter int unsigned RST_CYCLES = 7,
  parameter int unsigned INT_CYCLES = 7,
  parameter int unsigned MIN_LEN    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic [2:0] len,
  input  logic       ext_ok,
  input  logic       is_branch,
  input  logic       branch_taken,
  input  logic       page_cross,
  input  logic       irq_n,
  input  logic       i_flag,
  output logic       sync,
  output logic [2:0] tstate,
  output logic       last_cycle,
  output logic       rst_seq,
  output logic       int_seq,
  output logic       vec_fetch
);

  localparam int unsigned TW = 3;
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] RST_VEC   = TW'(RST_CYCLES - 2);
  localparam logic [TW-1:0] INT_LAST  = TW'(INT_CYCLES - 1);
  localparam logic [TW-1:0] INT_VEC   = TW'(INT_CYCLES - 2);
  localparam logic [TW-1:0] MIN_LEN_W = TW'(MIN_LEN);
  localparam logic [TW-1:0] T_MAX     = TW'(7);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_INT   = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] len_eff;
  logic          ext_allow;
  logic          ext_done;

  logic [TW-1:0] len_t1;
  logic          ext_allow_t1;
  logic          ext_t1;
  logic [TW:0]   fin_t1;
  logic          last_t1;
  logic [TW-1:0] t_next;
  logic          ext_hit;
  logic          ext_next;
  logic [TW:0]   fin_next;
  logic          last_next;
  logic          int_req;

`ifdef CPU_TIMING_INT_EN
  // Interrupt pending: level request with interrupts enabled
  assign int_req = !irq_n && !i_flag;
`else
  logic unused_int;
  assign int_req    = 1'b0;
  assign unused_int = ^{irq_n, i_flag, INT_LAST};
`endif

  // Instruction length and extension bookkeeping for the T0->T1 edge
  always_comb begin
    len_t1 = (len < MIN_LEN_W) ? MIN_LEN_W : len;
    if (is_branch) begin
      len_t1 = branch_taken ? TW'(3) : TW'(2);
    end
    ext_allow_t1 = is_branch ? branch_taken : ext_ok;
    // T1 is the base final cycle only for a 2-cycle opcode
    ext_t1  = ext_allow_t1 && page_cross && (len_t1 == TW'(2));
    fin_t1  = {1'b0, len_t1} - (TW+1)'(1) + (TW+1)'(ext_t1);
    last_t1 = (fin_t1 <= (TW+1)'(1));
  end

  // Next T-state and extension decision for EXEC/RST/INT advancing edges
  always_comb begin
    t_next    = tstate + TW'(1);
    ext_hit   = ext_allow && page_cross && !ext_done &&
                ({1'b0, t_next} == ({1'b0, len_eff} - (TW+1)'(1)));
    ext_next  = ext_done || ext_hit;
    fin_next  = {1'b0, len_eff} - (TW+1)'(1) + (TW+1)'(ext_next);
    last_next = ({1'b0, t_next} >= fin_next) || (t_next == T_MAX);
  end

  // Sequencer state and registered outputs; rdy=0 freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RST;
      tstate     <= '0;
      sync       <= 1'b0;
      last_cycle <= 1'b0;
      rst_seq    <= 1'b1;
      int_seq    <= 1'b0;
      vec_fetch  <= 1'b0;
      len_eff    <= MIN_LEN_W;
      ext_allow  <= 1'b0;
      ext_done   <= 1'b0;
    end else if (rdy) begin
      case (state)
        ST_RST: begin
          if (tstate == RST_LAST) begin
            state     <= ST_FETCH;
            tstate    <= '0;
            sync      <= 1'b1;
            rst_seq   <= 1'b0;
            vec_fetch <= 1'b0;
          end else begin
            tstate    <= t_next;
            vec_fetch <= (t_next == RST_VEC) || (t_next == RST_LAST);
          end
        end
        ST_FETCH: begin
          state      <= ST_EXEC;
          tstate     <= TW'(1);
          sync       <= 1'b0;
          len_eff    <= len_t1;
          ext_allow  <= ext_allow_t1;
          ext_done   <= ext_t1;
          last_cycle <= last_t1;
        end
        ST_EXEC: begin
          if (last_cycle) begin
            last_cycle <= 1'b0;
            ext_done   <= 1'b0;
            tstate     <= '0;
            if (int_req) begin
              state     <= ST_INT;
              int_seq   <= 1'b1;
              vec_fetch <= (INT_VEC == TW'(0));
            end else begin
              state <= ST_FETCH;
              sync  <= 1'b1;
            end
          end else begin
            tstate     <= t_next;
            ext_done   <= ext_next;
            last_cycle <= last_next;
          end
        end
`ifdef CPU_TIMING_INT_EN
        ST_INT: begin
          if (tstate == INT_LAST) begin
            state     <= ST_FETCH;
            tstate    <= '0;
            sync      <= 1'b1;
            int_seq   <= 1'b0;
            vec_fetch <= 1'b0;
          end else begin
            tstate    <= t_next;
            vec_fetch <= (t_next == INT_VEC) || (t_next == INT_LAST);
          end
        end
`endif
        default: begin
          state   <= ST_RST;
          tstate  <= '0;
          rst_seq <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_timing.md
Name: cpu_timing

Overview:
- Cycle sequencer for the 6502 core.
- Generates `sync` (opcode-fetch cycle marker) and the T-state count. Directly feeds the instruction register, which latches the opcode on the rising edge of `sync`.
- Consumes per-opcode cycle info from the decoder and page-cross/branch status from the address path.
- Owns the reset and interrupt entry sequences.

Parameters:
- RST_CYCLES, 7: length of the post-reset sequence before the first opcode fetch.
- INT_CYCLES, 7: length of the interrupt entry sequence.
- MIN_LEN, 2: minimum instruction length in cycles; smaller `len` values are clamped to this.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- rdy  in  1  1 = advance; 0 = freeze all state
- len  in  3  base cycle count of current opcode (decoder), valid during T1
- ext_ok  in  1  opcode may take +1 cycle on page cross, valid during T1
- is_branch  in  1  opcode is a conditional branch, valid during T1
- branch_taken  in  1  branch condition true, valid during T1
- page_cross  in  1  effective-address carry out of low byte
- irq_n  in  1  level interrupt request, active-low
- i_flag  in  1  interrupt disable flag
- sync  out  1  high during opcode-fetch cycle (T0)
- tstate  out  3  current cycle index within instruction/sequence
- last_cycle  out  1  final cycle of current instruction
- rst_seq  out  1  reset sequence in progress
- int_seq  out  1  interrupt sequence in progress
- vec_fetch  out  1  vector byte fetch cycle (last two cycles of RST/INT)

Behaviour:
- States: RST, FETCH, EXEC, INT. All outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- Reset (async assert):
  - state=RST, tstate=0, rst_seq=1.
  - sync=0, last_cycle=0, int_seq=0, vec_fetch=0.
  - Internal len_eff = MIN_LEN, extension flags cleared.
- Reset asserted mid-instruction or mid-sequence aborts immediately to RST.
- RST:
  - tstate counts 0..RST_CYCLES-1.
  - vec_fetch=1 at tstate RST_CYCLES-2 and RST_CYCLES-1.
  - After the final cycle: FETCH, tstate=0, rst_seq=0.
- FETCH: sync=1, tstate=0; next cycle goes to EXEC with tstate=1.
- EXEC, at tstate=1:
  - Latch len_eff = max(len, MIN_LEN); 3-bit field, max 7.
  - If is_branch: len_eff=2, plus 1 if branch_taken.
- EXEC extensions:
  - Page-cross: if ext_ok (latched at T1) and page_cross=1 in cycle tstate = len_eff-1, add one cycle. Applies at most once.
  - Branch page-cross: if the branch is taken and page_cross=1 at tstate=2, add one cycle (max total 4).
  - Extensions saturate at tstate=7; len_eff+ext > 7 is not produced by the decoder. If it occurs, the instruction ends at tstate=7.
- last_cycle=1 when tstate equals the final cycle index after extension, i.e. the extension is already visible in the same cycle.
- Leaving EXEC, in the cycle after last_cycle:
  - INT if an interrupt is pending (see feature).
  - Otherwise FETCH.
- sync:
  - Exactly one cycle per instruction; never high in RST or INT.
  - Back-to-back instructions give sync period = instruction length.
- rdy=0:
  - State, tstate and all outputs hold; inputs are ignored that cycle.
  - page_cross and branch_taken are sampled only on cycles with rdy=1.
  - rdy deasserted during FETCH holds sync high, so the IR sees a single rising edge.
- INT:
  - int_seq=1, tstate counts 0..INT_CYCLES-1.
  - vec_fetch=1 in the last two cycles.
  - Then FETCH.

Optional Feature:
- Macro: CPU_TIMING_INT_EN.
- Defined:
  - Pending = (irq_n==0 && i_flag==0), sampled in the last_cycle cycle with rdy=1.
  - If pending, the next state is INT instead of FETCH.
  - irq_n asserted in any other cycle is not latched (level-sensitive; must be held).
- Undefined:
  - irq_n and i_flag are ignored, the INT state is absent, and int_seq is tied 0.
  - vec_fetch occurs only in RST.

Test Plan:
- Release rst_n, rdy=1 -> rst_seq=1 for 7 cycles, vec_fetch at tstate 5,6, then sync=1 at the 8th cycle with tstate=0.
- Stream len=2,4,3 (ext_ok=0) -> sync pulses spaced 2,4,3 cycles; last_cycle at tstate 1,3,2 respectively.
- len=4, ext_ok=1, page_cross=1 at tstate 3 -> last_cycle at tstate 4, 5-cycle instruction; same opcode with page_cross=0 -> 4 cycles.
- Branch: not taken -> 2 cycles; taken, no cross -> 3; taken with page_cross at T2 -> 4.
- rdy=0 for 3 cycles during FETCH, then during EXEC tstate=2 -> sync stays high for 4 cycles with a single rising edge; tstate holds at 2; total length +3 cycles per stall.
- CPU_TIMING_INT_EN defined, irq_n=0, i_flag=0 at last_cycle -> int_seq=1 for 7 cycles with vec_fetch at tstate 5,6, then sync. With i_flag=1 -> normal FETCH. Macro undefined -> irq ignored.
- rst_n asserted at EXEC tstate 3 -> same-cycle sync=0 and rst_seq=1, full 7-cycle reset sequence follows.
